// File: rtl/rvfi_retire_sequencer.sv
// rtl/rvfi_retire_sequencer.sv - RVFI retirement port driver fed by a buffered valid/ready record stream
`ifndef RISCV_FORMAL_NRET
`define RISCV_FORMAL_NRET 1
`endif
`ifndef RISCV_FORMAL_XLEN
`define RISCV_FORMAL_XLEN 32
`endif

module rvfi_retire_sequencer #(
    parameter int NRET  = `RISCV_FORMAL_NRET,
    parameter int XLEN  = `RISCV_FORMAL_XLEN,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_insn,
    input  logic [XLEN-1:0]        in_pc,
    input  logic                   in_halt,
    input  logic                   stall,
    output logic [NRET-1:0]        rvfi_valid,
    output logic [64*NRET-1:0]     rvfi_order,
    output logic [32*NRET-1:0]     rvfi_insn,
    output logic [XLEN*NRET-1:0]   rvfi_pc_rdata,
    output logic [NRET-1:0]        rvfi_halt,
    output logic                   done
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]     mem_insn [DEPTH];
    logic [XLEN-1:0] mem_pc   [DEPTH];
    logic [DEPTH-1:0] mem_halt;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] k;
    logic [63:0]   next_order;
    logic          halt_seen;
    logic          push;
    logic          halt_pop;
    logic [NRET-1:0] pop_en;
    logic [PW-1:0] rd_idx [NRET];

    // Ready is purely a function of registered state so upstream never sees a loop through stall/valid.
    assign in_ready = (count < CW'(DEPTH)) && !halt_seen;
    assign push     = in_valid && in_ready;

    always_comb begin
        k        = '0;
        halt_pop = 1'b0;
        if (!stall) begin
            k = (count < CW'(NRET)) ? count : CW'(NRET);
        end
        for (int j = 0; j < NRET; j++) begin
            rd_idx[j] = PW'((int'(rd_ptr) + j) % DEPTH);
            pop_en[j] = CW'(j) < k;
            if (pop_en[j] && mem_halt[rd_idx[j]]) begin
                halt_pop = 1'b1;
            end
        end
    end

    // Storage needs no reset: count and the pointers define which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_insn[wr_ptr] <= in_insn;
            mem_pc[wr_ptr]   <= in_pc;
            mem_halt[wr_ptr] <= in_halt;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            next_order    <= '0;
            halt_seen     <= 1'b0;
            done          <= 1'b0;
            rvfi_valid    <= '0;
            rvfi_halt     <= '0;
            rvfi_order    <= '0;
            rvfi_insn     <= '0;
            rvfi_pc_rdata <= '0;
        end else begin
            if (push) begin
                wr_ptr <= PW'((int'(wr_ptr) + 1) % DEPTH);
                if (in_halt) begin
                    halt_seen <= 1'b1;
                end
            end
            rd_ptr <= PW'((int'(rd_ptr) + int'(k)) % DEPTH);
            count  <= count + CW'(push) - k;
            if (k != '0) begin
                next_order <= next_order + 64'(k);
            end
            if (halt_pop) begin
                done <= 1'b1;
            end
            // Popped entries fill channels from 0 upward, so valid lanes are always contiguous.
            for (int j = 0; j < NRET; j++) begin
                rvfi_valid[j] <= pop_en[j];
                rvfi_halt[j]  <= pop_en[j] && mem_halt[rd_idx[j]];
                if (pop_en[j]) begin
                    rvfi_order[64*j +: 64]      <= next_order + 64'(j);
                    rvfi_insn[32*j +: 32]       <= mem_insn[rd_idx[j]];
                    rvfi_pc_rdata[XLEN*j +: XLEN] <= mem_pc[rd_idx[j]];
                end
            end
        end
    end

endmodule

// File: tb/tb_rvfi_retire_sequencer.sv
// tb/tb_rvfi_retire_sequencer.sv - directed bench for rvfi_retire_sequencer (single and dual channel)
module tb_rvfi_retire_sequencer;

    logic        clock;
    logic        resetn;

    logic        in_valid, in_ready, in_halt, stall, done;
    logic [31:0] in_insn, in_pc;
    logic [0:0]  rvfi_valid, rvfi_halt;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn, rvfi_pc_rdata;

    logic         in_valid_b, in_ready_b, in_halt_b, stall_b, done_b;
    logic [31:0]  in_insn_b, in_pc_b;
    logic [1:0]   rvfi_valid_b, rvfi_halt_b;
    logic [127:0] rvfi_order_b;
    logic [63:0]  rvfi_insn_b, rvfi_pc_rdata_b;

    int n_checks;
    int n_fail;

    rvfi_retire_sequencer #(.NRET(1), .XLEN(32), .DEPTH(4)) dut (
        .clock(clock), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn), .in_pc(in_pc),
        .in_halt(in_halt), .stall(stall),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_halt(rvfi_halt), .done(done)
    );

    rvfi_retire_sequencer #(.NRET(2), .XLEN(32), .DEPTH(4)) dut2 (
        .clock(clock), .resetn(resetn),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_insn(in_insn_b), .in_pc(in_pc_b),
        .in_halt(in_halt_b), .stall(stall_b),
        .rvfi_valid(rvfi_valid_b), .rvfi_order(rvfi_order_b), .rvfi_insn(rvfi_insn_b),
        .rvfi_pc_rdata(rvfi_pc_rdata_b), .rvfi_halt(rvfi_halt_b), .done(done_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs;
        in_valid = 0; in_halt = 0; stall = 0; in_pc = '0; in_insn = '0;
        in_valid_b = 0; in_halt_b = 0; stall_b = 0; in_pc_b = '0; in_insn_b = '0;
    endtask

    task automatic do_reset;
        resetn = 0;
        clear_inputs();
        tick();
        tick();
        resetn = 1;
    endtask

    task automatic test_reset;
        resetn = 0;
        clear_inputs();
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_low: got %b, required 1", in_ready); end
        n_checks++;
        if (rvfi_valid !== 1'b0 || rvfi_order !== 64'd0 || rvfi_pc_rdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_outputs: valid=%b order=%h pc=%h, required 0", rvfi_valid, rvfi_order, rvfi_pc_rdata);
        end
        n_checks++;
        if (done !== 1'b0 || rvfi_halt !== 1'b0) begin n_fail++; $display("FAIL reset_done: done=%b halt=%b, required 0", done, rvfi_halt); end
        resetn = 1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || rvfi_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: ready=%b valid=%b, required 1/0", in_ready, rvfi_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] epc;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            in_valid = (c < 5);
            in_pc    = 32'h100 + 32'(4 * c);
            in_insn  = {in_pc[19:0], 12'h013};
            tick();
            n_checks++;
            if (rvfi_valid !== ((c >= 1 && c <= 5) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL b2b_valid c=%0d: got %b", c, rvfi_valid);
            end
            if (c >= 1 && c <= 5) begin
                epc = 32'h100 + 32'(4 * (c - 1));
                n_checks++;
                if (rvfi_order !== 64'(c - 1) || rvfi_pc_rdata !== epc || rvfi_insn !== {epc[19:0], 12'h013}) begin
                    n_fail++;
                    $display("FAIL b2b_data c=%0d: order=%0d pc=%h insn=%h, required order=%0d pc=%h", c, rvfi_order, rvfi_pc_rdata, rvfi_insn, c - 1, epc);
                end
            end
        end
        in_valid = 0;
    endtask

    task automatic test_stall_full;
        int acc;
        int ret;
        bit will_acc;
        do_reset();
        stall = 1;
        acc = 0;
        ret = 0;
        for (int c = 0; c < 30; c++) begin
            if (c == 10) stall = 0;
            in_valid = (acc < 6);
            in_pc    = 32'h200 + 32'(4 * acc);
            in_insn  = {in_pc[19:0], 12'h013};
            will_acc = in_valid && in_ready;
            tick();
            if (will_acc) acc++;
            if (c < 10) begin
                n_checks++;
                if (rvfi_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid c=%0d: got %b, required 0", c, rvfi_valid); end
            end
            if (c == 9) begin
                n_checks++;
                if (acc != 4 || in_ready !== 1'b0) begin
                    n_fail++; $display("FAIL stall_full: accepted=%0d ready=%b, required 4/0", acc, in_ready);
                end
            end
            if (c == 10) begin
                n_checks++;
                if (rvfi_valid !== 1'b1 || rvfi_order !== 64'd0 || in_ready !== 1'b1) begin
                    n_fail++; $display("FAIL stall_release: valid=%b order=%0d ready=%b, required 1/0/1", rvfi_valid, rvfi_order, in_ready);
                end
            end
            if (rvfi_valid === 1'b1) begin
                n_checks++;
                if (rvfi_order !== 64'(ret) || rvfi_pc_rdata !== 32'h200 + 32'(4 * ret)) begin
                    n_fail++; $display("FAIL stall_seq: order=%0d pc=%h, required order=%0d pc=%h", rvfi_order, rvfi_pc_rdata, ret, 32'h200 + 32'(4 * ret));
                end
                ret++;
            end
        end
        in_valid = 0;
        n_checks++;
        if (acc != 6 || ret != 6) begin n_fail++; $display("FAIL stall_total: accepted=%0d retired=%0d, required 6/6", acc, ret); end
    endtask

    task automatic test_dual_channel;
        do_reset();
        stall_b = 1;
        for (int c = 0; c < 3; c++) begin
            in_valid_b = 1;
            in_pc_b    = 32'h600 + 32'(4 * c);
            in_insn_b  = {in_pc_b[19:0], 12'h013};
            tick();
        end
        in_valid_b = 0;
        tick();
        n_checks++;
        if (rvfi_valid_b !== 2'b00) begin n_fail++; $display("FAIL dual_stalled: got %b, required 00", rvfi_valid_b); end
        stall_b = 0;
        tick();
        n_checks++;
        if (rvfi_valid_b !== 2'b11 || rvfi_order_b[63:0] !== 64'd0 || rvfi_order_b[127:64] !== 64'd1) begin
            n_fail++; $display("FAIL dual_first: valid=%b o0=%0d o1=%0d, required 11/0/1", rvfi_valid_b, rvfi_order_b[63:0], rvfi_order_b[127:64]);
        end
        n_checks++;
        if (rvfi_pc_rdata_b[31:0] !== 32'h600 || rvfi_pc_rdata_b[63:32] !== 32'h604) begin
            n_fail++; $display("FAIL dual_first_pc: pc0=%h pc1=%h, required 600/604", rvfi_pc_rdata_b[31:0], rvfi_pc_rdata_b[63:32]);
        end
        tick();
        n_checks++;
        if (rvfi_valid_b !== 2'b01 || rvfi_order_b[63:0] !== 64'd2 || rvfi_pc_rdata_b[31:0] !== 32'h608) begin
            n_fail++; $display("FAIL dual_second: valid=%b o0=%0d pc0=%h, required 01/2/608", rvfi_valid_b, rvfi_order_b[63:0], rvfi_pc_rdata_b[31:0]);
        end
        tick();
        n_checks++;
        if (rvfi_valid_b !== 2'b00) begin n_fail++; $display("FAIL dual_drain: got %b, required 00", rvfi_valid_b); end
    endtask

    task automatic test_halt;
        int n;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            n = c + 1;
            in_valid = 1;
            in_pc    = 32'h300 + 32'(4 * c);
            in_insn  = {in_pc[19:0], 12'h013};
            in_halt  = (c == 2);
            tick();
            n_checks++;
            if (rvfi_valid !== ((n >= 2 && n <= 4) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL halt_valid n=%0d: got %b", n, rvfi_valid);
            end
            if (n >= 2 && n <= 4) begin
                n_checks++;
                if (rvfi_order !== 64'(n - 2) || rvfi_halt !== ((n == 4) ? 1'b1 : 1'b0)) begin
                    n_fail++; $display("FAIL halt_data n=%0d: order=%0d halt=%b, required order=%0d", n, rvfi_order, rvfi_halt, n - 2);
                end
            end
            n_checks++;
            if (done !== ((n >= 4) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL halt_done n=%0d: got %b", n, done); end
            n_checks++;
            if (in_ready !== ((n < 3) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL halt_ready n=%0d: got %b", n, in_ready); end
        end
        in_valid = 0;
        in_halt  = 0;
    endtask

    task automatic test_order_wrap;
        int n;
        logic [63:0] eo;
        do_reset();
        dut.next_order = 64'hFFFF_FFFF_FFFF_FFFE;
        for (int c = 0; c < 6; c++) begin
            n = c + 1;
            in_valid = (c < 3);
            in_pc    = 32'h700 + 32'(4 * c);
            in_insn  = {in_pc[19:0], 12'h013};
            tick();
            if (n >= 2 && n <= 4) begin
                eo = (n == 2) ? 64'hFFFF_FFFF_FFFF_FFFE : (n == 3) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0;
                n_checks++;
                if (rvfi_valid !== 1'b1 || rvfi_order !== eo) begin
                    n_fail++; $display("FAIL wrap_order n=%0d: valid=%b order=%h, required 1/%h", n, rvfi_valid, rvfi_order, eo);
                end
            end
        end
        in_valid = 0;
    endtask

    task automatic test_async_reset;
        do_reset();
        stall = 1;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1;
            in_pc    = 32'h400 + 32'(4 * c);
            in_insn  = {in_pc[19:0], 12'h013};
            tick();
        end
        in_valid = 0;
        stall    = 0;
        tick();
        n_checks++;
        if (rvfi_valid !== 1'b1 || rvfi_pc_rdata !== 32'h400) begin
            n_fail++; $display("FAIL arst_pre: valid=%b pc=%h, required 1/400", rvfi_valid, rvfi_pc_rdata);
        end
        stall = 1;
        #2;
        resetn = 0;
        #1;
        n_checks++;
        if (rvfi_valid !== 1'b0 || rvfi_order !== 64'd0 || rvfi_pc_rdata !== 32'd0 || rvfi_insn !== 32'd0) begin
            n_fail++; $display("FAIL arst_outputs: valid=%b order=%0d pc=%h insn=%h, required 0", rvfi_valid, rvfi_order, rvfi_pc_rdata, rvfi_insn);
        end
        n_checks++;
        if (in_ready !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL arst_ready: ready=%b done=%b, required 1/0", in_ready, done); end
        tick();
        resetn   = 1;
        stall    = 0;
        in_valid = 1;
        in_pc    = 32'h500;
        in_insn  = {in_pc[19:0], 12'h013};
        tick();
        in_valid = 0;
        n_checks++;
        if (rvfi_valid !== 1'b0) begin n_fail++; $display("FAIL arst_flushed: valid=%b pc=%h, required 0", rvfi_valid, rvfi_pc_rdata); end
        tick();
        n_checks++;
        if (rvfi_valid !== 1'b1 || rvfi_order !== 64'd0 || rvfi_pc_rdata !== 32'h500 || done !== 1'b0) begin
            n_fail++; $display("FAIL arst_restart: valid=%b order=%0d pc=%h done=%b, required 1/0/500/0", rvfi_valid, rvfi_order, rvfi_pc_rdata, done);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        resetn   = 0;
        clear_inputs();
        test_reset();
        test_back_to_back();
        test_stall_full();
        test_dual_channel();
        test_halt();
        test_order_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
